uart_digit_rx: RTL
==================

# uart_digit_rx

Serial receiver at the Bluetooth end of the display path. It deserialises 8N1 UART frames from the Bluetooth module's TX line and decodes ASCII digits '0'–'9' into a 4-bit digit plus a one-cycle strobe. The 7-segment driver consumes that digit in place of its free-running counter; every received byte is also exposed for diagnostics.

## Interface
- CLKS_PER_BIT, 1406, clk cycles per UART bit (13.5 MHz / 9600 baud); must be ≥ 8.
- clk  in  1  system clock, 13.5 MHz nominal.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line from the Bluetooth module; idle high; asynchronous to clk.
- byte_o  out  8  last correctly framed byte.
- byte_valid  out  1  one-cycle pulse; byte_o updated this cycle.
- digit_o  out  4  last received ASCII digit value, 0–9.
- digit_valid  out  1  one-cycle pulse; digit_o updated this cycle.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- parity_err  out  1  one-cycle pulse; parity mismatch (constant 0 without UART_RX_PARITY_EN).

## Operation
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Reset values: byte_o=0x00, digit_o=0, all pulse outputs 0, state IDLE, counters 0, synchroniser flops 1.
- IDLE: wait for rx_s==0, then clear bit counter and baud counter and go to START.
- START: at the mid-bit point, rx_s==1 means a false start (glitch): return to IDLE and produce no output. rx_s==0 goes to DATA.
- DATA: sample 8 bits, LSB first, one per bit period at mid-bit. After bit 7, go to STOP (PARITY first if enabled).
- STOP, sample 1: update byte_o and pulse byte_valid, then go to IDLE.
  - If byte_o is in 0x30–0x39, also set digit_o = byte − 0x30 and pulse digit_valid in the same cycle.
  - Other bytes (CR, LF, letters) leave digit_o unchanged and produce no digit_valid.
- STOP, sample 0: pulse frame_err, leave byte_o/digit_o unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one frame_err, not repeated frames.
- Mid-bit point: baud counter == CLKS_PER_BIT/2 − 1 (integer division) in START; baud counter == CLKS_PER_BIT − 1 thereafter. The counter clears at each sample.
- The pulse outputs are mutually exclusive except byte_valid+digit_valid. Each is high for exactly one cycle.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded. After release, the receiver resyncs on the next falling edge seen in IDLE; a frame already in progress may produce frame_err or a garbage byte, which is acceptable.

## Timing
- T0 = first clk edge where rx_s==0 in IDLE. Let H = CLKS_PER_BIT/2.
  - Start sample: T0 + H.
  - Data bit k: T0 + H + (k+1)·CLKS_PER_BIT.
  - Stop sample: T0 + H + 9·CLKS_PER_BIT (10· with parity).
- Outputs register on the clk edge after the stop sample, i.e. +1 cycle.
- Latency from rx pin falling edge to byte_valid: 2 (sync) + 1 (T0) + H + 9·CLKS_PER_BIT + 1 cycles, ±1 for pin-edge phase.
- Back-to-back frames with no idle gap after stop are received without loss. IDLE is re-entered half a bit before the next start edge.
- Baud tolerance: ±2 % transmitter error is received correctly.

## Configuration
- UART_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit at mid-bit.
  - Frame becomes 8E1 and the stop sample moves one bit later.
  - Mismatch with a good stop bit: pulse parity_err, suppress byte_valid/digit_valid, leave outputs unchanged.
  - A stop error takes precedence: frame_err only.
- UART_RX_PARITY_EN undefined: 8N1, no PARITY state, parity_err tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Send 0x37 ('7') -> byte_valid and digit_valid pulse together once; byte_o=0x37, digit_o=7; frame_err=0.
- Send 0x41 ('A') after '7' -> byte_valid pulse with byte_o=0x41; digit_valid stays 0; digit_o holds 7.
- Drive rx low for 5 cycles then high -> no outputs pulse; the next frame '3' decodes to digit_o=3.
- Send 0x35 with the stop bit forced low, then hold rx low for 40 bit times, then release and send '9' -> exactly one frame_err; byte_o unchanged; then digit_o=9.
- Send "0","1",…,"9" back-to-back with no idle gap -> 10 digit_valid pulses, digit_o sequence 0..9, byte_valid count 10.
- With UART_RX_PARITY_EN: send 0x31 with the wrong parity bit -> parity_err pulses once, no byte_valid; 0x31 with correct parity -> digit_o=1. Assert rst_n mid-frame -> all outputs are at reset values within 1 cycle.

Source files
------------

// File: rtl/uart_digit_rx.sv
// 8N1 UART receiver that decodes ASCII '0'-'9' into a 4-bit digit with a strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_digit_rx #(
    parameter int CLKS_PER_BIT = 1406
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic [3:0] digit_o,
    output logic       digit_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               w_sample;
    logic [7:0]         w_byte_nxt;
    logic [3:0]         w_digit_nxt;
    logic               w_byte_valid_nxt;
    logic               w_digit_valid_nxt;
    logic               w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad;
    logic               w_parity_err_nxt;
`endif

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Mid-bit strobe: half a bit into the start bit, a full bit thereafter.
    always_comb begin
        if (r_state == S_START) begin
            w_sample = (r_baud_cnt == HALF_LAST);
        end else begin
            w_sample = (r_baud_cnt == FULL_LAST);
        end
    end

    // Baud/bit counters, data shift register and parity tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= {CNT_W{1'b0}};
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_BREAK: begin
                    r_baud_cnt <= {CNT_W{1'b0}};
                    r_bit_cnt  <= 3'd0;
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_START, S_PARITY, S_STOP: begin
                    if (w_sample) begin
                        r_baud_cnt <= {CNT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                        if (r_state == S_PARITY) begin
                            r_par_bad <= (w_rx_s != even_parity(r_shift));
                        end else begin
                            r_par_bad <= r_par_bad;
                        end
`endif
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= {CNT_W{1'b0}};
                    r_bit_cnt  <= 3'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_sample && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_sample) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_STOP: begin
                if (w_sample) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BREAK;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: everything is decided at the stop-bit sample.
    always_comb begin
        w_byte_nxt        = byte_o;
        w_digit_nxt       = digit_o;
        w_byte_valid_nxt  = 1'b0;
        w_digit_valid_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err_nxt  = 1'b0;
`endif
        if ((r_state == S_STOP) && w_sample) begin
            if (!w_rx_s) begin
                w_frame_err_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
                w_parity_err_nxt = 1'b1;
`endif
            end else begin
                w_byte_nxt       = r_shift;
                w_byte_valid_nxt = 1'b1;
                // Low nibble of ASCII '0'..'9' is the digit value itself.
                if (is_digit(r_shift)) begin
                    w_digit_nxt       = r_shift[3:0];
                    w_digit_valid_nxt = 1'b1;
                end else begin
                    w_digit_valid_nxt = 1'b0;
                end
            end
        end else begin
            w_frame_err_nxt = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_o      <= 8'h00;
            digit_o     <= 4'd0;
            byte_valid  <= 1'b0;
            digit_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_o      <= w_byte_nxt;
            digit_o     <= w_digit_nxt;
            byte_valid  <= w_byte_valid_nxt;
            digit_valid <= w_digit_valid_nxt;
            frame_err   <= w_frame_err_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Registered parity error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_parity_err_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
